// File: rtl/id_issue_arbiter_if.sv
// Decode-port bundle for id_issue_arbiter: fetch source, injection source,
// decode-stage handshake, burst status and FSM debug state.
interface id_issue_arbiter_if #(
  parameter int ENTRY_W = 32,
  parameter int CNT_W   = 5
);
  // Every source uses valid/ack: a transfer happens in a cycle where valid
  // and ack are both 1; ack without valid is ignored, and valid may be
  // withdrawn freely because the mux has no storage.
  logic               flush_i;
  logic [ENTRY_W-1:0] fetch_entry_i;
  logic               fetch_valid_i;
  logic               fetch_ack_o;
  logic               inj_req_i;
  logic [ENTRY_W-1:0] inj_entry_i;
  logic               inj_valid_i;
  logic               inj_last_i;
  logic               inj_ack_o;
  logic               inj_gnt_o;
  logic               id_empty_i;
  logic [ENTRY_W-1:0] entry_o;
  logic               entry_valid_o;
  logic               entry_ack_i;
  logic               inj_active_o;
  logic [CNT_W-1:0]   inj_count_o;
  logic [1:0]         state_dbg_o;

  // Arbiter side.
  modport slave (
    input  flush_i, fetch_entry_i, fetch_valid_i, inj_req_i, inj_entry_i,
           inj_valid_i, inj_last_i, id_empty_i, entry_ack_i,
    output fetch_ack_o, inj_ack_o, inj_gnt_o, entry_o, entry_valid_o,
           inj_active_o, inj_count_o, state_dbg_o
  );

  // Surrounding pipeline side (fetch FIFO, injector, decode stage).
  modport master (
    output flush_i, fetch_entry_i, fetch_valid_i, inj_req_i, inj_entry_i,
           inj_valid_i, inj_last_i, id_empty_i, entry_ack_i,
    input  fetch_ack_o, inj_ack_o, inj_gnt_o, entry_o, entry_valid_o,
           inj_active_o, inj_count_o, state_dbg_o
  );
endinterface

// File: rtl/id_issue_arbiter.sv
// Decode-port arbiter between the fetch stream and an exclusive, ordered
// injection source; drains the ID stage before each injected burst segment.
module id_issue_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  id_issue_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DRAIN  = 2'd1,
    S_INJECT = 2'd2,
    S_YIELD  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic sel_fetch;
  logic sel_inj;
  logic fetch_xfer;
  logic inj_xfer;

  // YIELD muxes exactly like FETCH; DRAIN points at the injector but is never valid.
  assign sel_fetch  = (state_q == S_FETCH) || (state_q == S_YIELD);
  assign sel_inj    = (state_q == S_INJECT);
  assign fetch_xfer = sel_fetch && bus.fetch_valid_i && bus.entry_ack_i;
  assign inj_xfer   = sel_inj && bus.inj_valid_i && bus.entry_ack_i;

  assign bus.entry_o       = sel_fetch ? bus.fetch_entry_i : bus.inj_entry_i;
  assign bus.entry_valid_o = sel_fetch ? bus.fetch_valid_i
                                       : (sel_inj && bus.inj_valid_i);
  assign bus.fetch_ack_o   = fetch_xfer;
  assign bus.inj_ack_o     = inj_xfer;
  assign bus.inj_gnt_o     = sel_inj;
  assign bus.inj_active_o  = (state_q != S_FETCH);
  assign bus.inj_count_o   = cnt_q;
  assign bus.state_dbg_o   = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = bus.inj_req_i ? S_DRAIN : S_FETCH;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (bus.inj_req_i) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (!bus.inj_req_i)      state_d = S_FETCH;
          else if (bus.id_empty_i) state_d = S_INJECT;
        end
        S_INJECT: begin
          if (!bus.inj_req_i) begin
            state_d = S_FETCH;
            cnt_d   = '0;
          end else if (inj_xfer) begin
            if (bus.inj_last_i) begin
              state_d = S_FETCH;
              cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
              // Segment full: hand one slot back to fetch before draining again.
              state_d = S_YIELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_YIELD: begin
          if (!bus.inj_req_i) state_d = S_FETCH;
          else if (fetch_xfer) state_d = S_DRAIN;
        end
        default: begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_issue_arbiter.sv
// Self-checking bench for id_issue_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a phase-level reference model.
module tb_id_issue_arbiter;

  localparam int MAX_BURST = 4;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);
  localparam int ENTRY_W   = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  id_issue_arbiter_if #(.ENTRY_W(ENTRY_W), .CNT_W(CNT_W)) bus ();

  id_issue_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: which source owns the port, and how many injected
  // entries the current segment has taken.
  typedef enum int {P_FETCH, P_DRAIN, P_INJECT, P_YIELD} phase_e;
  phase_e m_phase;
  int     m_cnt;
  int     fx_cnt;  // fetch transfers seen by the model
  int     ix_cnt;  // injected transfers seen by the model
  int     yield_fx;

  logic [ENTRY_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.flush_i       = 1'b0;
    bus.fetch_entry_i = '0;
    bus.fetch_valid_i = 1'b0;
    bus.inj_req_i     = 1'b0;
    bus.inj_entry_i   = '0;
    bus.inj_valid_i   = 1'b0;
    bus.inj_last_i    = 1'b0;
    bus.id_empty_i    = 1'b0;
    bus.entry_ack_i   = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven: check outputs, then
  // advance the model across the rising edge.
  task automatic cycle();
    bit fmux, imux, fx, ix;
    #1;
    fmux = (m_phase == P_FETCH) || (m_phase == P_YIELD);
    imux = (m_phase == P_INJECT);
    fx   = fmux && bus.fetch_valid_i && bus.entry_ack_i;
    ix   = imux && bus.inj_valid_i && bus.entry_ack_i;
    chk("entry_valid", bus.entry_valid_o,
        fmux ? bus.fetch_valid_i : (imux ? bus.inj_valid_i : 1'b0));
    if (fmux) chk("entry_fetch", bus.entry_o, bus.fetch_entry_i);
    if (imux) chk("entry_inj", bus.entry_o, bus.inj_entry_i);
    chk("fetch_ack", bus.fetch_ack_o, fx);
    chk("inj_ack", bus.inj_ack_o, ix);
    chk("inj_gnt", bus.inj_gnt_o, imux);
    chk("inj_active", bus.inj_active_o, m_phase != P_FETCH);
    chk("inj_count", bus.inj_count_o, m_cnt);
    if (ix && exp_q.size() > 0) chk("inj_order", bus.entry_o, exp_q.pop_front());
    @(posedge clk_i);
    if (fx) fx_cnt++;
    if (ix) ix_cnt++;
    if (fx && m_phase == P_YIELD) yield_fx++;
    if (bus.flush_i) begin
      m_phase = bus.inj_req_i ? P_DRAIN : P_FETCH;
      m_cnt   = 0;
    end else if (m_phase == P_FETCH) begin
      if (bus.inj_req_i) m_phase = P_DRAIN;
    end else if (m_phase == P_DRAIN) begin
      if (!bus.inj_req_i) m_phase = P_FETCH;
      else if (bus.id_empty_i) m_phase = P_INJECT;
    end else if (m_phase == P_INJECT) begin
      if (!bus.inj_req_i) begin
        m_phase = P_FETCH; m_cnt = 0;
      end else if (ix) begin
        m_cnt++;
        if (bus.inj_last_i) begin
          m_phase = P_FETCH; m_cnt = 0;
        end else if (m_cnt == MAX_BURST) begin
          m_phase = P_YIELD; m_cnt = 0;
        end
      end
    end else begin
      if (!bus.inj_req_i) m_phase = P_FETCH;
      else if (fx) m_phase = P_DRAIN;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_gnt", bus.inj_gnt_o, 1'b0);
    chk("rst_active", bus.inj_active_o, 1'b0);
    chk("rst_count", bus.inj_count_o, 0);
    chk("rst_inj_ack", bus.inj_ack_o, 1'b0);
    m_phase = P_FETCH;
    m_cnt   = 0;
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int sent, guard, fx0;
    rst_ni = 1'b1;
    idle_inputs();
    @(negedge clk_i);
    do_reset();

    // 1: plain fetch streaming.
    fx_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_valid_i = 1'b1; bus.entry_ack_i = 1'b1;
      bus.fetch_entry_i = $urandom;
      cycle();
    end
    chk("t1_fetch_acks", fx_cnt, 4);

    // 2: request, drain for 3 cycles, 3-entry burst.
    bus.inj_req_i = 1'b1;
    fx0 = fx_cnt;
    cycle();
    chk("t2_req_cycle_fetch", fx_cnt - fx0, 1);
    for (int i = 0; i < 3; i++) cycle();
    bus.id_empty_i = 1'b1;
    cycle();
    chk("t2_gnt", bus.inj_gnt_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.inj_valid_i = 1'b1; bus.inj_entry_i = $urandom;
      bus.inj_last_i = (i == 2);
      exp_q.push_back(bus.inj_entry_i);
      cycle();
      chk("t2_count", bus.inj_count_o, (i == 2) ? 0 : i + 1);
    end
    chk("t2_back_to_fetch", bus.inj_active_o, 1'b0);

    // 3: 6-entry burst forces a yield after MAX_BURST entries.
    ix_cnt = 0; yield_fx = 0; sent = 0; guard = 0;
    bus.inj_req_i = 1'b1; bus.id_empty_i = 1'b1; bus.inj_last_i = 1'b0;
    cycle();
    while (sent < 6 && guard < 40) begin
      bus.fetch_entry_i = $urandom;
      bus.inj_entry_i   = $urandom;
      bus.inj_last_i    = (sent == 5);
      if (m_phase == P_INJECT) begin
        exp_q.push_back(bus.inj_entry_i);
        sent++;
      end
      cycle();
      guard++;
    end
    chk("t3_bound", guard < 40, 1'b1);
    chk("t3_injected", ix_cnt, 6);
    chk("t3_yield_fetch", yield_fx, 1);
    chk("t3_end_fetch", bus.inj_active_o, 1'b0);

    // 4: flush after 2 injected entries with the request held.
    bus.inj_last_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.inj_entry_i = $urandom;
      cycle();
    end
    chk("t4_count_before", bus.inj_count_o, 2);
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0; bus.id_empty_i = 1'b0;
    chk("t4_count_cleared", bus.inj_count_o, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t4_still_draining", bus.inj_gnt_o, 1'b0);
    bus.id_empty_i = 1'b1;
    cycle();
    chk("t4_regranted", bus.inj_gnt_o, 1'b1);

    // 5: abort mid-INJECT, then abort from DRAIN.
    cycle();
    bus.inj_req_i = 1'b0;
    cycle();
    chk("t5_abort_inject", bus.inj_active_o, 1'b0);
    bus.inj_req_i = 1'b1; bus.id_empty_i = 1'b0;
    cycle();
    bus.inj_req_i = 1'b0;
    cycle();
    chk("t5_abort_drain", bus.inj_active_o, 1'b0);
    fx0 = fx_cnt;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_fetch_resumes", fx_cnt - fx0, 3);

    // 6: asynchronous reset with three entries in the segment.
    bus.inj_req_i = 1'b1; bus.id_empty_i = 1'b1;
    cycle(); cycle();
    for (int i = 0; i < 3; i++) cycle();
    bus.inj_valid_i = 1'b0;
    cycle();
    chk("t6_count_pre", bus.inj_count_o, 3);
    do_reset();

    // Random traffic with a sticky request.
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) bus.inj_req_i = ~bus.inj_req_i;
      bus.flush_i       = ($urandom_range(0, 19) == 0);
      bus.fetch_valid_i = $urandom_range(0, 1);
      bus.fetch_entry_i = $urandom;
      bus.inj_valid_i   = $urandom_range(0, 1);
      bus.inj_entry_i   = $urandom;
      bus.inj_last_i    = ($urandom_range(0, 5) == 0);
      bus.id_empty_i    = $urandom_range(0, 1);
      bus.entry_ack_i   = $urandom_range(0, 1);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
